// File: rtl/mttkrp_pkg.sv
// Shared types and constants for the MTTKRP datapath blocks.
package mttkrp_pkg;

    localparam int DEF_RANK_FACTOR_MATRIX = 16;
    localparam int DEF_N                  = 32;

    typedef logic [DEF_RANK_FACTOR_MATRIX-1:0][DEF_N-1:0] vec_t;

    // Requester-ID width; never zero so a single requester still has a tag bit.
    function automatic int tag_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with full/empty/count status. DEPTH must be a power of 2.
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is not reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/qadd_sched.sv
// Round-robin scheduler sharing one qadd vector adder among NUM_REQ requesters.
// Results return in issue order through a credit-protected result FIFO.
module qadd_sched
    import mttkrp_pkg::*;
#(
    parameter int RANK_FACTOR_MATRIX = DEF_RANK_FACTOR_MATRIX,
    parameter int N                  = DEF_N,
    parameter int NUM_REQ            = 4,
    parameter int RES_DEPTH          = 4,
    localparam int TW                = tag_width(NUM_REQ)
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [NUM_REQ-1:0]                                req_valid,
    output logic [NUM_REQ-1:0]                                req_ready,
    input  logic [NUM_REQ-1:0][RANK_FACTOR_MATRIX-1:0][N-1:0] req_a,
    input  logic [NUM_REQ-1:0][RANK_FACTOR_MATRIX-1:0][N-1:0] req_b,
    output logic                                              add_in_avl0,
    output logic                                              add_in_avl1,
    output logic [RANK_FACTOR_MATRIX-1:0][N-1:0]              add_a,
    output logic [RANK_FACTOR_MATRIX-1:0][N-1:0]              add_b,
    input  logic                                              add_out_avl,
    input  logic [RANK_FACTOR_MATRIX-1:0][N-1:0]              add_c,
    output logic                                              res_valid,
    input  logic                                              res_ready,
    output logic [RANK_FACTOR_MATRIX-1:0][N-1:0]              res_data,
    output logic [TW-1:0]                                     res_tag,
    output logic                                              busy
);

    localparam int VW = RANK_FACTOR_MATRIX * N;
    localparam int CW = $clog2(RES_DEPTH + 1);

    logic [TW-1:0]      rr_ptr;
    logic [TW-1:0]      win;
    logic [TW:0]        cand_sum;
    logic               transfer;
    logic               credit_ok;
    logic [CW-1:0]      credits;
    logic               res_pop;
    logic               issue_q;
    logic [TW-1:0]      issue_tag_q;
    logic               ret_accept;
    logic [TW-1:0]      tag_head;
    logic               tag_full;
    logic               tag_empty;
    logic [CW-1:0]      tag_count;
    logic [VW+TW-1:0]   res_head;
    logic               res_full;
    logic               res_empty;
    logic [CW-1:0]      res_count;

    // A pop frees a slot in the same cycle, so it may fund a grant immediately.
    assign res_valid   = !res_empty;
    assign res_pop     = res_valid && res_ready;
    assign credit_ok   = (credits != '0) || res_pop;
    assign add_in_avl0 = issue_q;
    assign add_in_avl1 = issue_q;
    assign ret_accept  = add_out_avl && !tag_empty;
    assign res_data    = res_empty ? '0 : res_head[VW+TW-1:TW];
    assign res_tag     = res_empty ? '0 : res_head[TW-1:0];
    assign busy        = issue_q || (tag_count != '0) || (res_count != '0);

    // Round-robin search starting at rr_ptr; grant is forced low during reset.
    always_comb begin
        req_ready = '0;
        win       = '0;
        transfer  = 1'b0;
        cand_sum  = '0;
        if (rst && credit_ok) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand_sum = {1'b0, rr_ptr} + (TW+1)'(i);
                if (cand_sum >= (TW+1)'(NUM_REQ)) cand_sum = cand_sum - (TW+1)'(NUM_REQ);
                if (!transfer && req_valid[cand_sum[TW-1:0]]) begin
                    transfer                     = 1'b1;
                    win                          = cand_sum[TW-1:0];
                    req_ready[cand_sum[TW-1:0]]  = 1'b1;
                end
            end
        end
    end

    // Issue stage: operands and strobe registered one cycle after the transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_q     <= 1'b0;
            issue_tag_q <= '0;
            add_a       <= '0;
            add_b       <= '0;
        end else begin
            issue_q <= transfer;
            if (transfer) begin
                issue_tag_q <= win;
                add_a       <= req_a[win];
                add_b       <= req_b[win];
            end
        end
    end

    // Pointer advance and credit accounting; credits track FIFO slots not yet claimed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= '0;
            credits <= CW'(RES_DEPTH);
        end else begin
            if (transfer) rr_ptr <= (win == TW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            case ({transfer, res_pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    sync_fifo #(.WIDTH(TW), .DEPTH(RES_DEPTH)) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .push  (issue_q),
        .din   (issue_tag_q),
        .pop   (ret_accept),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    sync_fifo #(.WIDTH(VW + TW), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ret_accept),
        .din   ({add_c, tag_head}),
        .pop   (res_pop),
        .dout  (res_head),
        .full  (res_full),
        .empty (res_empty),
        .count (res_count)
    );

    // Outstanding ops never exceed RES_DEPTH, so a full queue leaves no spare credit.
    a_res_full_no_credit: assert property (@(posedge clk) disable iff (!rst)
        res_full |-> (credits == '0));
    a_tag_full_no_issue: assert property (@(posedge clk) disable iff (!rst)
        tag_full |-> !issue_q);
    a_credit_bound: assert property (@(posedge clk) disable iff (!rst)
        credits <= CW'(RES_DEPTH));

endmodule
